// File: rtl/ss_stack.sv
// rtl/ss_stack.sv - eForth1 data-stack responder, TOS cached; SS_STACK_GUARD_EN adds sticky ovf/udf flags
module ss_stack #(
    parameter int DSZ   = 8,
    parameter int DEPTH = 16,
    parameter int SSZ   = $clog2(DEPTH + 1)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [1:0]     op,
    input  logic [DSZ-1:0] vi,
    input  logic           clr,
    output logic [DSZ-1:0] tos,
    output logic [DSZ-1:0] nos,
    output logic [SSZ-1:0] sp,
    output logic           empty,
    output logic           full,
    output logic           ovf,
    output logic           udf
);

    localparam logic [1:0] OP_NOP  = 2'b00;
    localparam logic [1:0] OP_PUSH = 2'b01;
    localparam logic [1:0] OP_POP  = 2'b10;
    localparam logic [1:0] OP_RPL  = 2'b11;
    localparam int AW = (DEPTH > 2) ? $clog2(DEPTH - 1) : 1;

    logic [DSZ-1:0] arr [DEPTH-1];
    logic [DSZ-1:0] tos_r, tos_nxt;
    logic [SSZ-1:0] sp_r, sp_nxt;
    logic [SSZ-1:0] spm1, spm2;
    logic           wr_en;

    assign spm1  = sp_r - SSZ'(1);
    assign spm2  = sp_r - SSZ'(2);
    assign empty = (sp_r == '0);
    assign full  = (sp_r == SSZ'(DEPTH));
    assign sp    = sp_r;
    assign tos   = tos_r;
    // Cells above sp are stale; only expose the array once it holds a real NOS.
    assign nos   = (sp_r >= SSZ'(2)) ? arr[spm2[AW-1:0]] : '0;

    always_comb begin
        sp_nxt  = sp_r;
        tos_nxt = tos_r;
        wr_en   = 1'b0;
        case (op)
            OP_NOP: ;
            OP_PUSH: begin
                if (!full) begin
                    wr_en   = !empty;
                    tos_nxt = vi;
                    sp_nxt  = sp_r + SSZ'(1);
                end
            end
            OP_POP: begin
                if (!empty) begin
                    tos_nxt = nos;
                    sp_nxt  = spm1;
                end
            end
            OP_RPL: begin
                tos_nxt = vi;
                if (empty) sp_nxt = SSZ'(1);
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sp_r  <= '0;
            tos_r <= '0;
        end else begin
            sp_r  <= sp_nxt;
            tos_r <= tos_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && wr_en) arr[spm1[AW-1:0]] <= tos_r;
    end

`ifdef SS_STACK_GUARD_EN
    logic ovf_r, udf_r;

    // A fresh violation outranks clr arriving in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_r <= 1'b0;
            udf_r <= 1'b0;
        end else begin
            if (op == OP_PUSH && full) ovf_r <= 1'b1;
            else if (clr)              ovf_r <= 1'b0;
            if (op == OP_POP && empty) udf_r <= 1'b1;
            else if (clr)              udf_r <= 1'b0;
        end
    end

    assign ovf = ovf_r;
    assign udf = udf_r;
`else
    logic unused_clr;
    assign unused_clr = clr;
    assign ovf = 1'b0;
    assign udf = 1'b0;
`endif

endmodule

// File: tb/tb_ss_stack.sv
// tb/tb_ss_stack.sv - table-driven bench for ss_stack at DEPTH=4
module tb_ss_stack;

`ifdef SS_STACK_GUARD_EN
    localparam logic G = 1'b1;
`else
    localparam logic G = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] op  = 2'b00;
    logic [7:0] vi  = 8'h00;
    logic       clr = 1'b0;
    logic [7:0] tos, nos;
    logic [2:0] sp;
    logic       empty, full, ovf, udf;

    int npass  = 0;
    int ncheck = 0;

    ss_stack #(.DSZ(8), .DEPTH(4)) dut (
        .clk(clk), .rst(rst), .op(op), .vi(vi), .clr(clr),
        .tos(tos), .nos(nos), .sp(sp), .empty(empty), .full(full),
        .ovf(ovf), .udf(udf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       r;
        logic [1:0] o;
        logic [7:0] v;
        logic       c;
        logic [2:0] esp;
        logic [7:0] etos;
        logic [7:0] enos;
        logic       eovf;
        logic       eudf;
        string      name;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic r, logic [1:0] o, logic [7:0] v, logic c,
                                logic [2:0] esp, logic [7:0] et, logic [7:0] en,
                                logic eo, logic eu, string name);
        vec_t x;
        x.r = r; x.o = o; x.v = v; x.c = c;
        x.esp = esp; x.etos = et; x.enos = en; x.eovf = eo; x.eudf = eu;
        x.name = name;
        return x;
    endfunction

    task automatic step(input vec_t x);
        logic [22:0] act, exp;
        @(negedge clk);
        rst = x.r; op = x.o; vi = x.v; clr = x.c;
        @(posedge clk);
        #1;
        act = {sp, tos, nos, empty, full, ovf, udf};
        exp = {x.esp, x.etos, x.enos, x.esp == 3'd0, x.esp == 3'd4, x.eovf, x.eudf};
        ncheck++;
        if (act !== exp)
            $display("FAIL %s: got sp/tos/nos/e/f/o/u=%h required %h", x.name, act, exp);
        else
            npass++;
    endtask

    initial begin
        //           rst op     vi     clr sp    tos    nos    ovf udf
        tbl.push_back(mk(1, 2'b00, 8'h00, 0, 3'd0, 8'h00, 8'h00, 0, 0, "reset"));
        tbl.push_back(mk(1, 2'b01, 8'h55, 0, 3'd0, 8'h00, 8'h00, 0, 0, "reset_push"));
        tbl.push_back(mk(0, 2'b00, 8'h00, 0, 3'd0, 8'h00, 8'h00, 0, 0, "idle"));
        tbl.push_back(mk(0, 2'b01, 8'h11, 0, 3'd1, 8'h11, 8'h00, 0, 0, "push1"));
        tbl.push_back(mk(0, 2'b01, 8'h22, 0, 3'd2, 8'h22, 8'h11, 0, 0, "push2"));
        tbl.push_back(mk(0, 2'b01, 8'h33, 0, 3'd3, 8'h33, 8'h22, 0, 0, "push3"));
        tbl.push_back(mk(0, 2'b01, 8'h44, 0, 3'd4, 8'h44, 8'h33, 0, 0, "push4_full"));
        tbl.push_back(mk(0, 2'b01, 8'h99, 0, 3'd4, 8'h44, 8'h33, G, 0, "push_full"));
        tbl.push_back(mk(0, 2'b00, 8'h00, 0, 3'd4, 8'h44, 8'h33, G, 0, "ovf_sticky"));
        tbl.push_back(mk(0, 2'b00, 8'h00, 1, 3'd4, 8'h44, 8'h33, 0, 0, "ovf_clr"));
        tbl.push_back(mk(0, 2'b01, 8'h99, 1, 3'd4, 8'h44, 8'h33, G, 0, "ovf_set_wins"));
        tbl.push_back(mk(0, 2'b00, 8'h00, 1, 3'd4, 8'h44, 8'h33, 0, 0, "ovf_clr2"));
        tbl.push_back(mk(0, 2'b10, 8'h00, 0, 3'd3, 8'h33, 8'h22, 0, 0, "pop1"));
        tbl.push_back(mk(0, 2'b10, 8'h00, 0, 3'd2, 8'h22, 8'h11, 0, 0, "pop2"));
        tbl.push_back(mk(0, 2'b11, 8'hAB, 0, 3'd2, 8'hAB, 8'h11, 0, 0, "rpl_sp2"));
        tbl.push_back(mk(0, 2'b10, 8'h00, 0, 3'd1, 8'h11, 8'h00, 0, 0, "pop3"));
        tbl.push_back(mk(0, 2'b10, 8'h00, 0, 3'd0, 8'h00, 8'h00, 0, 0, "pop4_empty"));
        tbl.push_back(mk(0, 2'b10, 8'h00, 0, 3'd0, 8'h00, 8'h00, 0, G, "pop_empty"));
        tbl.push_back(mk(0, 2'b11, 8'h07, 0, 3'd1, 8'h07, 8'h00, 0, G, "rpl_empty"));
        tbl.push_back(mk(0, 2'b00, 8'h00, 1, 3'd1, 8'h07, 8'h00, 0, 0, "udf_clr"));
        tbl.push_back(mk(0, 2'b11, 8'h01, 0, 3'd1, 8'h01, 8'h00, 0, 0, "rpl_sp1"));

        foreach (tbl[i]) step(tbl[i]);

        for (int k = 0; k < 10; k++) begin
            step(mk(0, 2'b01, 8'h5A, 0, 3'd2, 8'h5A, 8'h01, 0, 0, "alt_push"));
            step(mk(0, 2'b10, 8'h00, 0, 3'd1, 8'h01, 8'h00, 0, 0, "alt_pop"));
        end

        step(mk(0, 2'b01, 8'h02, 0, 3'd2, 8'h02, 8'h01, 0, 0, "fill2"));
        step(mk(0, 2'b01, 8'h03, 0, 3'd3, 8'h03, 8'h02, 0, 0, "fill3"));
        step(mk(1, 2'b01, 8'h77, 0, 3'd0, 8'h00, 8'h00, 0, 0, "mid_reset"));
        step(mk(0, 2'b01, 8'h10, 0, 3'd1, 8'h10, 8'h00, 0, 0, "push_after_reset"));

        @(negedge clk);
        op = 2'b00;
        $display("%0d/%0d checks passed", npass, ncheck);
        $finish;
    end

endmodule
